// File: rtl/ram_arb_pkg.sv
// Shared encodings for the byte-enabled RAM arbiter: owner states and byte-lane enables.
// Pure declarations; no logic, no latency, no flow control.
// Imported by ram_arb_pick and ram_byte_arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } owner_e;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for two requesters: locked owner first, then round-robin (or fixed priority).
// Purely combinational; a locked owner yields once the other port has waited out the burst limit.
// RAM_ARB_FIXED_PRIO_EN: fixed priority port 0 over port 1 instead of round-robin.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic [1:0]    req,
  input  owner_e        owner,
  input  logic          lock_held,
  input  logic [CW-1:0] burst_cnt,
  input  logic          last,
  output logic [1:0]    gnt
);

  logic burst_full;

  assign burst_full = (burst_cnt == CW'(MAX_BURST - 1));

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    gnt = 2'b00;
    if (lock_held && (owner == OWN0) && req[0]) begin
      gnt = (req[1] && burst_full) ? 2'b10 : 2'b01;
    end else if (lock_held && (owner == OWN1) && req[1]) begin
      gnt = (req[0] && burst_full) ? 2'b01 : 2'b10;
    end else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
`else
      // On a tie the port that did not win last goes next.
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
`endif
    end
  end

endmodule

// File: rtl/ram_byte_arbiter.sv
// Shares one single-port byte-enabled RAM between two masters with round-robin and burst locking.
// Grant and RAM drive are combinational; read data returns registered one cycle after the grant.
// Losers hold req until granted. RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first).
module ram_byte_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [1:0]            be0,
  input  logic [1:0]            be1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [1:0]            ram_byte_ena,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] burst_q, burst_d, burst_inc;
  logic [1:0]    gnt_raw, gnt;

  ram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_pick (
    .req       ({req1, req0}),
    .owner     (owner_q),
    .lock_held (owner_q != OWN_NONE),
    .burst_cnt (burst_q),
    .last      (last_q),
    .gnt       (gnt_raw)
  );

  // Nothing reaches the RAM while reset is held.
  assign gnt  = rst ? 2'b00 : gnt_raw;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    ram_we       = 1'b0;
    ram_byte_ena = BE_NONE;
    ram_addr     = '0;
    ram_wdata    = '0;
    if (gnt[0]) begin
      ram_we       = we0 & (|be0);
      ram_byte_ena = be0;
      ram_addr     = addr0;
      ram_wdata    = wdata0;
    end else if (gnt[1]) begin
      ram_we       = we1 & (|be1);
      ram_byte_ena = be1;
      ram_addr     = addr1;
      ram_wdata    = wdata1;
    end
  end

  assign burst_inc = (burst_q == CW'(MAX_BURST - 1)) ? burst_q : burst_q + CW'(1);

  always_comb begin
    owner_d = OWN_NONE;
    burst_d = '0;
    last_d  = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
      if (lock0) begin
        owner_d = OWN0;
        burst_d = (owner_q == OWN0) ? burst_inc : '0;
      end
    end else if (gnt[1]) begin
      last_d = 1'b1;
      if (lock1) begin
        owner_d = OWN1;
        burst_d = (owner_q == OWN1) ? burst_inc : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt[0] & ~we0;
      rvalid1 <= gnt[1] & ~we1;
      if (gnt[0] && !we0) rdata0 <= ram_rdata;
      if (gnt[1] && !we1) rdata1 <= ram_rdata;
    end
  end

endmodule
